sync_fifo_thr: RTL



---
 rtl/sync_fifo_thr.sv | 95 +++++++++
 1 files changed

// File: rtl/sync_fifo_thr.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// an occupancy count, sticky overflow/underflow flags and an optional FWFT read mode.
module sync_fifo_thr #(
  parameter int unsigned D_WIDTH  = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2,
  parameter bit          FWFT     = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     winc,
  input  logic [D_WIDTH-1:0]       wdata,
  output logic                     wfull,
  output logic                     walmost_full,
  input  logic                     rinc,
  output logic [D_WIDTH-1:0]       rdata,
  output logic                     rempty,
  output logic                     ralmost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [D_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wptr_q, wptr_d;
  logic [AW-1:0]      rptr_q, rptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;
  logic               wr_acc_c, rd_acc_c;

  // Flags decode from the count register only, so they never glitch mid-cycle.
  assign wfull         = (count_q == CW'(DEPTH));
  assign walmost_full  = (count_q >= CW'(AF_LEVEL));
  assign rempty        = (count_q == '0);
  assign ralmost_empty = (count_q <= CW'(AE_LEVEL));
  assign count         = count_q;
  assign overflow      = ovf_q;
  assign underflow     = udf_q;

  always_comb begin
    wr_acc_c = winc && !wfull;
    rd_acc_c = rinc && !rempty;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    if (wr_acc_c) wptr_d = wptr_q + AW'(1);
    if (rd_acc_c) rptr_d = rptr_q + AW'(1);
    unique case ({wr_acc_c, rd_acc_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A fresh error in the same cycle as clr_err keeps the flag set.
    ovf_d = (ovf_q && !clr_err) || (winc && wfull);
    udf_d = (udf_q && !clr_err) || (rinc && rempty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc_c) mem_q[wptr_q] <= wdata;
  end

  if (FWFT) begin : g_fwft
    assign rdata = rempty ? '0 : mem_q[rptr_q];
  end else begin : g_reg
    logic [D_WIDTH-1:0] rdata_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        rdata_q <= '0;
      else if (rd_acc_c) rdata_q <= mem_q[rptr_q];
    end
    assign rdata = rdata_q;
  end

endmodule
